uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit (even, >=4).
REQ-003 SHALL have parameter BAUD_DIV, default 27, clk_i cycles per oversample tick (>=1).
REQ-004 SHALL have parameter DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn_i, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en_i, input, 1, pop request.
REQ-009 SHALL have port rd_data_o, output, DATA_W, FIFO head (first-word fall-through).
REQ-010 SHALL have port empty_o, output, 1, FIFO empty.
REQ-011 SHALL have port full_o, output, 1, FIFO full.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1), FIFO occupancy.
REQ-013 SHALL have port frame_err_o, output, 1, one-cycle pulse on bad stop bit.
REQ-014 SHALL have port overrun_o, output, 1, one-cycle pulse on frame dropped because FIFO full.
REQ-015 SHALL have port parity_err_o, output, 1, one-cycle pulse on parity mismatch (present only under REQ-034).

Function
REQ-016 SHALL pass rx_i through a 2-flop synchroniser reset to 1; all decoding uses the synchronised value.
REQ-017 SHALL generate one-cycle tick every BAUD_DIV clk_i cycles from a free-running divider.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with an OVS-tick counter and a bit index.
REQ-019 IDLE->START on synchronised rx low at a tick; tick counter cleared.
REQ-020 START: after OVS/2 ticks sample; low -> DATA, high -> IDLE (glitch rejected, no error flagged).
REQ-021 DATA: sample every OVS ticks, shift LSB first; after DATA_W bits -> PARITY if enabled, else STOP.
REQ-022 STOP: sample after OVS ticks; high -> push candidate, low -> frame_err_o pulse, frame discarded; both -> IDLE.
REQ-023 Push SHALL occur in the cycle after the stop sample; push rejected when full and no simultaneous pop -> overrun_o pulse, FIFO unchanged.
REQ-024 Pop SHALL occur when rd_en_i=1 and empty_o=0; rd_en_i while empty ignored, no state change.
REQ-025 Simultaneous push and pop SHALL both succeed at any occupancy including full; count_o unchanged.
REQ-026 rd_data_o SHALL show the oldest entry combinationally from storage; value undefined-but-stable when empty (drive 0).
REQ-027 Read/write pointers SHALL be $clog2(DEPTH)+1 bits wrapping modulo 2*DEPTH; full/empty derived from MSB compare.
REQ-028 count_o, empty_o, full_o SHALL update the cycle after a push/pop edge.

Reset
REQ-029 On resetn_i low SHALL asynchronously enter IDLE, clear divider, tick/bit counters, shift register, pointers.
REQ-030 Reset values: rd_data_o=0, empty_o=1, full_o=0, count_o=0, frame_err_o=0, overrun_o=0, parity_err_o=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new falling edge.
REQ-032 Reset release SHALL be handled synchronously: first state change no earlier than the second clk_i edge after deassertion.

Configuration
REQ-033 Macro UART_RX_PARITY_EN SHALL add parameter PARITY_ODD (default 0 = even) and the PARITY state.
REQ-034 With UART_RX_PARITY_EN: PARITY samples one bit after data; mismatch -> parity_err_o pulse at stop handling and frame discarded (frame error takes precedence, only frame_err_o pulses); port parity_err_o exists.
REQ-035 Without UART_RX_PARITY_EN: no PARITY state, no parity_err_o port; DATA goes directly to STOP.

Verification
REQ-036 BAUD_DIV=1, OVS=16: frame 0xA5, stop high -> rd_data_o=0xA5, count_o=1, empty_o=0, no error pulses.
REQ-037 rx_i low for 4 clk_i then high -> FSM back to IDLE, count_o=0, no frame_err_o.
REQ-038 Frame 0x3C with stop bit low -> frame_err_o one-cycle pulse, count_o remains 0.
REQ-039 DEPTH=8: 9 frames 0x00..0x08 without reads -> full_o=1 after 8th, overrun_o pulse on 9th, pops return 0x00..0x07 in order.
REQ-040 FIFO full, rd_en_i=1 in push cycle of frame 0x55 -> count_o stays 8, 0x55 appears last in pop order.
REQ-041 Parity build, even, frame 0x01 with parity bit 0 -> parity_err_o pulse, frame discarded; parity bit 1 -> 0x01 stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a first-word-fall-through receive FIFO
// Define UART_RX_PARITY_EN to add the parity bit check (PARITY_ODD, parity_err_o).
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int OVS      = 16,
    parameter int BAUD_DIV = 27,
    parameter int DEPTH    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       rx_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef UART_RX_PARITY_EN
    output logic                       parity_err_o,
`endif
    output logic                       frame_err_o,
    output logic                       overrun_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW    = $clog2(OVS);
    localparam int BW    = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state;
    logic [1:0]          arm;
    logic                run;
    logic                rx_meta;
    logic                rx_s;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [TW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_idx;
    logic [DATA_W-1:0]   shreg;
    logic                push_req;
`ifdef UART_RX_PARITY_EN
    logic                par_bad;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Reset is released through two flops so nothing moves until the second edge after deassertion.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            arm <= 2'b00;
        end else begin
            arm <= {arm[0], 1'b1};
        end
    end

    assign run = arm[1];

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            div_cnt <= '0;
        end else if (run) begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = run && (div_cnt == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_req    <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            push_req    <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                        end
                    end
                    // A start bit that is high again at mid-bit was a glitch; drop back silently.
                    S_START: begin
                        if (tick_cnt == TW'(OVS / 2 - 1)) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == TW'(OVS - 1)) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_W-1:1]};
                            bit_idx  <= bit_idx + 1'b1;
                            if (bit_idx == BW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_cnt == TW'(OVS - 1)) begin
                            tick_cnt <= '0;
                            par_bad  <= (^shreg) ^ rx_s ^ PARITY_ODD;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    // Bad stop bit outranks bad parity: only one error pulse per frame.
                    S_STOP: begin
                        if (tick_cnt == TW'(OVS - 1)) begin
                            tick_cnt <= '0;
                            state    <= S_IDLE;
                            if (!rx_s) begin
                                frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err_o <= 1'b1;
`endif
                            end else begin
                                push_req <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign do_pop  = rd_en_i && !empty_o;
    assign do_push = push_req && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= push_req && full_o && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o   = wr_ptr - rd_ptr;
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo: vector table, corner sequences, randomized queue model
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int OVS   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    // Line edge -> 2 sync flops -> detect, half a bit to mid-start, whole bits to mid-stop, then one cycle to push.
    localparam int PUSH_EDGE  = 3 + OVS / 2 + OVS * (NBITS - 1) + 1;
    localparam int FRAME_CLKS = NBITS * OVS + 2 * OVS;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          rx     = 1'b1;
    logic          rd_en  = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
    int            pe_pulses = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int fe_pulses = 0;
    int ov_pulses = 0;
    int wide_pulses = 0;
    logic fe_d = 1'b0;
    logic ov_d = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       stop;
        logic       pop_first;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_W  (DW),
        .OVS     (OVS),
        .BAUD_DIV(1),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .rx_i        (rx),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .frame_err_o (frame_err),
        .overrun_o   (overrun)
    );

    always @(negedge clk) begin
        if (frame_err) fe_pulses++;
        if (overrun) ov_pulses++;
        if ((frame_err && fe_d) || (overrun && ov_d)) wide_pulses++;
        fe_d = frame_err;
        ov_d = overrun;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_pulses++;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one full frame one clock at a time; optionally pulses rd_en exactly on the push edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par,
                              input logic pop_at_push);
        logic [NBITS-1:0] frm;
`ifdef UART_RX_PARITY_EN
        frm = {stop, (^d) ^ flip_par, d, 1'b0};
`else
        frm = {stop, d, flip_par & 1'b0};
`endif
        for (int c = 0; c < FRAME_CLKS; c++) begin
            rx    = (c < NBITS * OVS) ? frm[c / OVS] : 1'b1;
            rd_en = pop_at_push && (c == PUSH_EDGE - 1);
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check(name, {24'h0, rd_data}, {24'h0, exp});
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rx     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int fe0, ov0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 0, 8'h00, 1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 1, 8'h5A, 0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 2, 8'h5A, 0, 0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 2, 8'h5A, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 2, 8'hFF, 0, 0};

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_data", {24'h0, rd_data}, 32'h0);
        check("reset empty", {31'h0, empty}, 32'h1);
        check("reset full", {31'h0, full}, 32'h0);
        check("reset count", {28'h0, count}, 32'h0);
        check("reset frame_err", {31'h0, frame_err}, 32'h0);
        check("reset overrun", {31'h0, overrun}, 32'h0);
`ifdef UART_RX_PARITY_EN
        check("reset parity_err", {31'h0, parity_err}, 32'h0);
`endif
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_pulses;
            ov0 = ov_pulses;
            if (vecs[i].pop_first) begin
                rd_en = 1'b1;
                @(posedge clk); #1;
                rd_en = 1'b0;
            end
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
            check($sformatf("vec%0d count", i), {28'h0, count}, vecs[i].exp_count);
            check($sformatf("vec%0d head", i), {24'h0, rd_data}, {24'h0, vecs[i].exp_head});
            check($sformatf("vec%0d empty", i), {31'h0, empty}, {31'h0, vecs[i].exp_count == 0});
            check($sformatf("vec%0d frame_err", i), fe_pulses - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d overrun", i), ov_pulses - ov0, vecs[i].exp_ov);
        end

        for (int i = 0; i < DEPTH + 2 && !empty; i++) begin
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
        end
        check("drain empty", {31'h0, empty}, 32'h1);

        // Short low glitch on an idle line must not start a frame.
        fe0 = fe_pulses;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * OVS) @(posedge clk);
        #1;
        check("glitch count", {28'h0, count}, 32'h0);
        check("glitch frame_err", fe_pulses - fe0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("after glitch count", {28'h0, count}, 32'h1);
        pop_check("after glitch data", 8'hC3);

        // Asynchronous reset in the middle of a frame.
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * OVS) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset count", {28'h0, count}, 32'h0);
        check("async reset empty", {31'h0, empty}, 32'h1);
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        fe0 = fe_pulses;
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        check("post reset count", {28'h0, count}, 32'h1);
        check("post reset frame_err", fe_pulses - fe0, 0);
        pop_check("post reset data", 8'h99);

        // Fill to full, then one more frame overruns.
        ov0 = ov_pulses;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == DEPTH - 1) begin
                check("fill full", {31'h0, full}, 32'h1);
                check("fill count", {28'h0, count}, DEPTH);
            end
        end
        check("overrun pulses", ov_pulses - ov0, 1);
        check("overrun count", {28'h0, count}, DEPTH);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("fill pop%0d", i), 8'(i));
        check("fill drained", {31'h0, empty}, 32'h1);

        // Pop in the same cycle as a push into a full FIFO.
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        ov0 = ov_pulses;
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        check("simul count", {28'h0, count}, DEPTH);
        check("simul full", {31'h0, full}, 32'h1);
        check("simul overrun", ov_pulses - ov0, 0);
        for (int i = 1; i < DEPTH; i++) pop_check($sformatf("simul pop%0d", i), 8'h10 + 8'(i));
        pop_check("simul last", 8'h55);
        check("simul drained", {31'h0, empty}, 32'h1);

`ifdef UART_RX_PARITY_EN
        begin
            int pe0;
            pe0 = pe_pulses;
            fe0 = fe_pulses;
            send_frame(8'h01, 1'b1, 1'b1, 1'b0);
            check("parity bad pulse", pe_pulses - pe0, 1);
            check("parity bad count", {28'h0, count}, 32'h0);
            send_frame(8'h01, 1'b1, 1'b0, 1'b0);
            check("parity good count", {28'h0, count}, 32'h1);
            check("parity good pulse", pe_pulses - pe0, 1);
            pop_check("parity good data", 8'h01);
            send_frame(8'h01, 1'b0, 1'b1, 1'b0);
            check("parity+stop frame_err", fe_pulses - fe0, 1);
            check("parity+stop parity_err", pe_pulses - pe0, 1);
            check("parity+stop count", {28'h0, count}, 32'h0);
        end
`endif

        // Randomized frames and pops against a queue model.
        q.delete();
        for (int it = 0; it < 40; it++) begin
            logic [7:0] d;
            logic       good;
            int         npop;
            int         exp_fe;
            int         exp_ov;
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                if (q.size() > 0) begin
                    pop_check($sformatf("rand%0d pop", it), q.pop_front());
                end else begin
                    rd_en = 1'b1;
                    @(posedge clk); #1;
                    rd_en = 1'b0;
                    check($sformatf("rand%0d empty pop count", it), {28'h0, count}, 32'h0);
                end
            end
            fe0 = fe_pulses;
            ov0 = ov_pulses;
            exp_fe = 0;
            exp_ov = 0;
            if (!good) exp_fe = 1;
            else if (q.size() < DEPTH) q.push_back(d);
            else exp_ov = 1;
            send_frame(d, good, 1'b0, 1'b0);
            check($sformatf("rand%0d count", it), {28'h0, count}, q.size());
            check($sformatf("rand%0d head", it), {24'h0, rd_data}, (q.size() > 0) ? {24'h0, q[0]} : 32'h0);
            check($sformatf("rand%0d frame_err", it), fe_pulses - fe0, exp_fe);
            check($sformatf("rand%0d overrun", it), ov_pulses - ov0, exp_ov);
        end

        check("pulse width", wide_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
